mem_dump_unit: RTL and testbench

Post-run memory readout engine for the single-cycle CPU: it is the reader for the word-addressed unified memory that the bench preloads.
- When the CPU signals halt, the block freezes the CPU.
- It then walks a fixed window of data memory (default word 2048..4095) through the memory's synchronous read port.
- Each word leaves on a valid/ready stream, so results can be checked or logged without hierarchical peeking.
- It sits beside the CPU top, sharing the memory's read port during the dump.

---
 rtl/mem_dump_pkg.sv | 23 ++
 rtl/mem_dump_checksum.sv | 34 +++
 rtl/mem_dump_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_dump_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg
// Shared types and constants for the post-run memory dump engine.
//   dump_state_t    : FSM state encoding
//   DEF_ADDR_W      : default word-address width of the unified memory
//   DEF_DATA_W      : default memory word width
//   CHK_MARKER_ADDR : all-ones marker address carried by the checksum beat
//                     (slice to the address width in use)
package mem_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_READ  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } dump_state_t;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    localparam logic [63:0] CHK_MARKER_ADDR = '1;

endpackage

// File: rtl/mem_dump_checksum.sv
// mem_dump_checksum
// Running additive (mod 2**DATA_W) sum of the words accepted on the dump
// stream. Clear has priority over accumulate.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears the sum
//   clr   : synchronous clear (start of a new dump)
//   acc   : add data into the sum this cycle
//   data  : word to accumulate
//   sum   : current running sum
module mem_dump_checksum
    import mem_dump_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              acc,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (acc) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/mem_dump_unit.sv
// mem_dump_unit
// Post-run readout engine. When the CPU halts, it freezes the CPU, waits one
// cycle for any in-flight store to land, then walks the window
// DUMP_BASE .. DUMP_BASE+DUMP_WORDS-1 through the memory's synchronous read
// port and emits each word on a valid/ready stream.
//
// Optional build macro MEM_DUMP_CHECKSUM_EN: appends one extra beat carrying
// the mod-2**DATA_W sum of all dumped words at the all-ones address; the
// last memory word then no longer carries dump_last.
//
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   halt_i             : CPU halt level, only acted on in IDLE
//   cpu_stall          : holds the CPU frozen from halt until reset
//   mem_rd_en/mem_addr : read request, data returns on mem_rd_data next cycle
//   dump_valid/ready   : stream handshake
//   dump_data/addr     : stream word and its word address
//   dump_last          : final beat of the dump
//   done               : sticky completion flag
//
// The next word is read while the current beat is still on the stream, so a
// word leaves every two cycles with ready high. This relies on the memory
// output register holding its value while mem_rd_en is low (the CPU is
// stalled, so nothing else reads the port during the dump).
module mem_dump_unit
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DUMP_BASE  = 2048,
    parameter int DUMP_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_i,
    output logic              cpu_stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              done
);

    generate
        if (DUMP_WORDS < 1 || (DUMP_BASE + DUMP_WORDS) > (2 ** ADDR_W)) begin : g_bad_window
            $error("mem_dump_unit: dump window does not fit the memory");
        end
    endgenerate

    localparam int                IDX_W    = $clog2(DUMP_WORDS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DUMP_WORDS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DUMP_BASE);

    dump_state_t      state;
    logic [IDX_W-1:0] index;
    logic             all_loaded;
    logic             accept;

    assign accept = dump_valid & dump_ready;

`ifdef MEM_DUMP_CHECKSUM_EN
    localparam logic [ADDR_W-1:0] MARKER = CHK_MARKER_ADDR[ADDR_W-1:0];

    logic [DATA_W-1:0] sum;
    logic              sum_beat;
    logic              sum_clr;
    logic              sum_acc;

    // The marker address may also be a real memory address, so the checksum
    // beat is tracked by flag rather than recognised by its address.
    assign sum_clr = (state == S_IDLE) && halt_i;
    assign sum_acc = accept && !sum_beat;

    mem_dump_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk   (clk),
        .reset (reset),
        .clr   (sum_clr),
        .acc   (sum_acc),
        .data  (dump_data),
        .sum   (sum)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            index      <= '0;
            all_loaded <= 1'b0;
            cpu_stall  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_beat   <= 1'b0;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            if (accept) begin
                dump_valid <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (halt_i) begin
                        state     <= S_DRAIN;
                        cpu_stall <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    state      <= S_READ;
                    index      <= '0;
                    all_loaded <= 1'b0;
                    mem_rd_en  <= 1'b1;
                    mem_addr   <= BASE;
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum_beat   <= 1'b0;
`endif
                end

                // Read strobe is high for this one cycle; the data is on
                // mem_rd_data from the next cycle onwards.
                S_READ: begin
                    state <= S_SEND;
                end

                // Load the fetched word once the stream slot is empty, and
                // issue the next read at the same time.
                S_SEND: begin
                    if (!dump_valid) begin
                        if (!all_loaded) begin
                            dump_data  <= mem_rd_data;
                            dump_addr  <= BASE + ADDR_W'(index);
                            dump_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                            dump_last  <= 1'b0;
`else
                            dump_last  <= (index == LAST_IDX);
`endif
                            if (index == LAST_IDX) begin
                                all_loaded <= 1'b1;
                            end else begin
                                index     <= index + IDX_ONE;
                                mem_rd_en <= 1'b1;
                                mem_addr  <= BASE + ADDR_W'(index + IDX_ONE);
                                state     <= S_READ;
                            end
                        end
`ifdef MEM_DUMP_CHECKSUM_EN
                        else if (!sum_beat) begin
                            dump_data  <= sum;
                            dump_addr  <= MARKER;
                            dump_last  <= 1'b1;
                            dump_valid <= 1'b1;
                            sum_beat   <= 1'b1;
                        end
`endif
                    end else if (dump_ready && dump_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_unit.sv
module tb_mem_dump_unit;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int BASE  = 2048;
    localparam int WORDS = 4;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          halt_i = 1'b0;
    logic          cpu_stall;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;
    logic          dump_last;
    logic          done;

    mem_dump_unit #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DUMP_BASE  (BASE),
        .DUMP_WORDS (WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halt_i      (halt_i),
        .cpu_stall   (cpu_stall),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_addr   (dump_addr),
        .dump_last   (dump_last),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Unified memory: synchronous read, output holds while not enabled.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    beats_acc = 0;
    int    rmode = 0;
    bit    hold_pending = 1'b0;
    beat_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the dump is the window in address order, optionally
    // followed by the wrapping sum at the all-ones address.
    task automatic push_expected();
        logic [DW-1:0] s;
        beat_t b;
        s = '0;
        for (int i = 0; i < WORDS; i++) begin
            b.addr = AW'(BASE + i);
            b.data = mem[BASE + i];
            b.last = !CHK && (i == WORDS - 1);
            s      = s + b.data;
            exp_q.push_back(b);
        end
        if (CHK) begin
            b.addr = '1;
            b.data = s;
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    // Ready generator
    initial begin
        logic pat [4];
        int   ph;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: dump_ready = 1'b1;
                1: begin dump_ready = pat[ph]; ph = (ph + 1) % 4; end
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_pending = 1'b0;
            end else if (dump_valid) begin
                if (hold_pending) begin
                    chk("hold_data", dump_data, held.data);
                    chk("hold_addr", dump_addr, held.addr);
                    chk("hold_last", dump_last, held.last);
                end
                if (dump_ready) begin
                    hold_pending = 1'b0;
                    beats_acc++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat_addr", dump_addr, 64'hDEAD_0000);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_addr", dump_addr, e.addr);
                        chk("beat_data", dump_data, e.data);
                        chk("beat_last", dump_last, e.last);
                    end
                end else begin
                    hold_pending = 1'b1;
                    held.addr = dump_addr;
                    held.data = dump_data;
                    held.last = dump_last;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return {3'b0, cpu_stall, mem_rd_en, mem_addr, dump_valid, dump_data,
                dump_addr, dump_last, done};
    endfunction

    task automatic apply_reset();
        #3;
        reset = 1'b0;
        #1;
        chk("reset_outputs", all_outs(), 64'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic do_dump(input bit hold, input bit timing);
        int kv;
        int kd;
        @(posedge clk);
        #1;
        halt_i = 1'b1;
        push_expected();
        @(posedge clk);
        #1;
        if (!hold) halt_i = 1'b0;
        chk("stall_after_halt", cpu_stall, 1);
        kv = -1;
        kd = -1;
        for (int k = 1; k <= 400 && kd < 0; k++) begin
            @(posedge clk);
            #1;
            if (timing && k == 1) begin
                chk("first_rd_en", mem_rd_en, 1);
                chk("first_rd_addr", mem_addr, BASE);
            end
            if (dump_valid && kv < 0) kv = k;
            if (done) kd = k;
        end
        if (kd < 0) chk("done_timeout", 0, 1);
        if (timing) begin
            chk("first_valid_cycle", kv, 3);
            chk("done_cycle", kd, 2 + 2 * WORDS + (CHK ? 2 : 0));
        end
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_state", {cpu_stall, mem_rd_en, dump_valid, done}, 4'b1001);
    endtask

    initial begin
        int b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        // Reset and idle
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_quiet", {cpu_stall, mem_rd_en, dump_valid, done}, 4'b0000);
        end

        // Basic dump, ready high, timing
        mem[BASE] = 32'h11; mem[BASE+1] = 32'h22; mem[BASE+2] = 32'h33; mem[BASE+3] = 32'h44;
        rmode = 0;
        do_dump(1'b0, 1'b1);

        // Ready 1-0-0-1 pattern
        apply_reset();
        rmode = 1;
        do_dump(1'b0, 1'b0);

        // Random data, random ready
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            for (int i = 0; i < WORDS; i++) mem[BASE + i] = $urandom;
            rmode = 2;
            do_dump(1'b0, 1'b0);
        end

        // Reset mid-dump after two beats, then dump again from the base
        apply_reset();
        mem[BASE] = 32'h11; mem[BASE+1] = 32'h22; mem[BASE+2] = 32'h33; mem[BASE+3] = 32'h44;
        rmode = 0;
        b0 = beats_acc;
        @(posedge clk);
        #1;
        halt_i = 1'b1;
        push_expected();
        @(posedge clk);
        #1;
        halt_i = 1'b0;
        for (int k = 0; k < 100 && beats_acc < b0 + 2; k++) @(posedge clk);
        if (beats_acc < b0 + 2) chk("mid_dump_timeout", 0, 1);
        apply_reset();
        do_dump(1'b0, 1'b0);

        // Halt held high through the dump and DONE, then re-pulsed
        apply_reset();
        b0 = beats_acc;
        do_dump(1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            halt_i = ~halt_i;
        end
        @(negedge clk);
        chk("single_dump_beats", beats_acc - b0, WORDS + (CHK ? 1 : 0));
        chk("done_sticky", {done, cpu_stall, dump_valid}, 3'b110);
        halt_i = 1'b0;

        // Wrapping sum data
        apply_reset();
        mem[BASE] = 32'hFFFF_FFFF; mem[BASE+1] = 32'h2; mem[BASE+2] = 32'h0; mem[BASE+3] = 32'h0;
        rmode = 1;
        do_dump(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
